// File: rtl/aud_player_if.sv
// Signal bundle between aud_player, the codec DAC pins, the SRAM read port and the top FSM.
interface aud_player_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 20
);
    logic              i_lrc;
    logic              i_start;
    logic              i_pause;
    logic              i_stop;
    logic              i_fast;
    logic [2:0]        i_speed;
    logic [ADDR_W-1:0] i_end_addr;
    logic [DATA_W-1:0] i_sram_data;
    logic [ADDR_W-1:0] o_address;
    logic              o_dacdat;
    logic              o_playing;
    logic              o_finished;

    modport slave (
        input  i_lrc, i_start, i_pause, i_stop, i_fast, i_speed, i_end_addr, i_sram_data,
        output o_address, o_dacdat, o_playing, o_finished
    );

    modport master (
        output i_lrc, i_start, i_pause, i_stop, i_fast, i_speed, i_end_addr, i_sram_data,
        input  o_address, o_dacdat, o_playing, o_finished
    );
endinterface

// File: rtl/aud_player.sv
// SRAM-to-WM8731 I2S playback engine with fast/slow speed control, clocked by codec BCLK.
// Define STEREO_DUP_EN to repeat each left sample on the right channel.
module aud_player #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned MAX_ADDR = 1023999
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    aud_player_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 2);
    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam int unsigned AW1   = ADDR_W + 1;
`ifdef STEREO_DUP_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_PAUSE} state_t;

    state_t            state;
    logic              lrc_q;
    logic              pause_pend;
    logic              fast_q;
    logic              right_half;
    logic [2:0]        speed_q;
    logic [2:0]        rep_cnt;
    logic [2:0]        rep_nxt;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [ADDR_W:0]   addr_nxt;
    logic              left_start;
    logic              right_start;
    logic              word_done;
    logic              last_word;
    logic              over;

    assign left_start  = lrc_q & ~bus.i_lrc;
    assign right_start = ~lrc_q & bus.i_lrc;
    assign word_done   = (bit_cnt == CNT_W'(DATA_W));
    assign last_word   = right_half | ~STEREO;
    assign bit_idx     = IDX_W'(DATA_W - 1 - 32'(bit_cnt));

    // One extra address bit keeps the end-of-data compare from wrapping.
    always_comb begin
        rep_nxt  = '0;
        addr_nxt = {1'b0, bus.o_address};
        if (fast_q) begin
            addr_nxt = {1'b0, bus.o_address} + AW1'(speed_q) + AW1'(1);
        end else if (speed_q == '0 || rep_cnt == speed_q) begin
            addr_nxt = {1'b0, bus.o_address} + AW1'(1);
        end else begin
            rep_nxt = rep_cnt + 3'd1;
        end
        over = (addr_nxt > {1'b0, bus.i_end_addr}) || (addr_nxt > AW1'(MAX_ADDR));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_IDLE;
            lrc_q          <= 1'b0;
            pause_pend     <= 1'b0;
            fast_q         <= 1'b0;
            right_half     <= 1'b0;
            speed_q        <= '0;
            rep_cnt        <= '0;
            shift          <= '0;
            bit_cnt        <= '0;
            bus.o_address  <= '0;
            bus.o_dacdat   <= 1'b0;
            bus.o_playing  <= 1'b0;
            bus.o_finished <= 1'b0;
        end else begin
            lrc_q          <= bus.i_lrc;
            bus.o_finished <= 1'b0;
            if (bus.i_stop && state != S_IDLE) begin
                state          <= S_IDLE;
                pause_pend     <= 1'b0;
                right_half     <= 1'b0;
                bit_cnt        <= '0;
                bus.o_address  <= '0;
                bus.o_dacdat   <= 1'b0;
                bus.o_playing  <= 1'b0;
                bus.o_finished <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.i_start) begin
                            state         <= S_WAIT;
                            bus.o_address <= '0;
                            rep_cnt       <= '0;
                            bus.o_playing <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (bus.i_pause) begin
                            state         <= S_PAUSE;
                            bus.o_playing <= 1'b0;
                        end else if (left_start) begin
                            shift        <= bus.i_sram_data;
                            bus.o_dacdat <= bus.i_sram_data[DATA_W-1];
                            bit_cnt      <= CNT_W'(1);
                            fast_q       <= bus.i_fast;
                            speed_q      <= bus.i_speed;
                            right_half   <= 1'b0;
                            state        <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        if (bus.i_pause) pause_pend <= 1'b1;
                        if (bit_cnt < CNT_W'(DATA_W)) begin
                            bus.o_dacdat <= shift[bit_idx];
                            bit_cnt      <= bit_cnt + CNT_W'(1);
                        end else if (word_done && !last_word) begin
                            // Left word done in stereo mode: park until the right half begins.
                            bus.o_dacdat <= 1'b0;
                            bit_cnt      <= CNT_W'(DATA_W + 1);
                        end else if (word_done) begin
                            bus.o_dacdat <= 1'b0;
                            bit_cnt      <= '0;
                            rep_cnt      <= rep_nxt;
                            if (over) begin
                                state          <= S_IDLE;
                                pause_pend     <= 1'b0;
                                bus.o_address  <= '0;
                                bus.o_playing  <= 1'b0;
                                bus.o_finished <= 1'b1;
                            end else begin
                                bus.o_address <= addr_nxt[ADDR_W-1:0];
                                if (pause_pend || bus.i_pause) begin
                                    state         <= S_PAUSE;
                                    pause_pend    <= 1'b0;
                                    bus.o_playing <= 1'b0;
                                end else begin
                                    state <= S_WAIT;
                                end
                            end
                        end else if (right_start) begin
                            bus.o_dacdat <= shift[DATA_W-1];
                            bit_cnt      <= CNT_W'(1);
                            right_half   <= 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        bus.o_dacdat <= 1'b0;
                        if (bus.i_start && !bus.i_pause) begin
                            state         <= S_WAIT;
                            bus.o_playing <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
